stage_cfg_sched: RTL and testbench

Per-stage configuration scheduler for one RMT stage (key extractor, lookup engine, action engine). Accepts table-write requests from the control channel and tracks in-flight PHVs between stage ingress and egress. It de-asserts stg_ready, drains the stage, issues exactly one write pulse to the selected table, waits a settle interval, then releases the pipeline. This guarantees no PHV is processed against a half-written entry.

---
 rtl/stage_cfg_sched_if.sv | 51 +++++
 rtl/stage_cfg_sched.sv | 199 +++++++++++++++++++
 tb/tb_stage_cfg_sched.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/stage_cfg_sched_if.sv
// Stage config/PHV-tracking bundle: control-channel request, PHV ingress/egress strobes, table write ports.
// slave = scheduler side, master = control/pipeline side.
interface stage_cfg_sched_if #(
    parameter int KEY_OFF = 18,
    parameter int KEY_LEN = 197,
    parameter int ACT_LEN = 25,
    parameter int ADDR_W  = 4
);
    logic                     phv_in_valid;
    logic                     phv_out_valid;
    logic                     stg_ready;

    logic                     cfg_valid;
    logic                     cfg_ready;
    logic [3:0]               cfg_stage;
    logic [1:0]               cfg_target;
    logic [ADDR_W-1:0]        cfg_addr;
    logic [ACT_LEN*25-1:0]    cfg_data;
    logic [KEY_LEN-1:0]       cfg_mask;
    logic                     cfg_err;
    logic                     protocol_err;

    logic [KEY_OFF-1:0]       key_off_entry_in;
    logic                     key_off_entry_in_valid;
    logic [ADDR_W-1:0]        key_off_entry_addr;
    logic [KEY_LEN-1:0]       lookup_din;
    logic [KEY_LEN-1:0]       lookup_din_mask;
    logic [ADDR_W-1:0]        lookup_din_addr;
    logic                     lookup_din_en;
    logic [ACT_LEN*25-1:0]    action_data_in;
    logic [ADDR_W-1:0]        action_addr;
    logic                     action_en;

    modport slave (
        input  phv_in_valid, phv_out_valid,
        input  cfg_valid, cfg_stage, cfg_target, cfg_addr, cfg_data, cfg_mask,
        output stg_ready, cfg_ready, cfg_err, protocol_err,
        output key_off_entry_in, key_off_entry_in_valid, key_off_entry_addr,
        output lookup_din, lookup_din_mask, lookup_din_addr, lookup_din_en,
        output action_data_in, action_addr, action_en
    );

    modport master (
        output phv_in_valid, phv_out_valid,
        output cfg_valid, cfg_stage, cfg_target, cfg_addr, cfg_data, cfg_mask,
        input  stg_ready, cfg_ready, cfg_err, protocol_err,
        input  key_off_entry_in, key_off_entry_in_valid, key_off_entry_addr,
        input  lookup_din, lookup_din_mask, lookup_din_addr, lookup_din_en,
        input  action_data_in, action_addr, action_en
    );
endinterface

// File: rtl/stage_cfg_sched.sv
// Drains one RMT stage, applies a single table write, settles, then releases; empty-stage write at T+2, cfg_ready at T+3+SETTLE_CYC.
// Backpressure: stg_ready drops the cycle after a request is accepted and returns the cycle after cfg_ready.
module stage_cfg_sched #(
    parameter int STAGE      = 0,
    parameter int PIPE_DEPTH = 8,
    parameter int KEY_OFF    = 18,
    parameter int KEY_LEN    = 197,
    parameter int ACT_LEN    = 25,
    parameter int ADDR_W     = 4,
    parameter int SETTLE_CYC = 2
) (
    input  logic                 axis_clk,
    input  logic                 axis_rst,
    stage_cfg_sched_if.slave     bus
);
    localparam int CNT_W = $clog2(PIPE_DEPTH + 1);
    localparam int DAT_W = ACT_LEN * 25;

    typedef enum logic [2:0] {IDLE, DRAIN, WRITE, SETTLE, DONE} state_t;

    state_t               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 perr_q, perr_d;
    logic                 stg_ready_q, stg_ready_d;
    logic                 cfg_ready_q, cfg_ready_d;
    logic                 cfg_err_q, cfg_err_d;
    logic [1:0]           tgt_q, tgt_d;
    logic [ADDR_W-1:0]    addr_q, addr_d;
    logic [DAT_W-1:0]     data_q, data_d;
    logic [KEY_LEN-1:0]   mask_q, mask_d;
    logic [3:0]           settle_q, settle_d;
    logic                 key_en_q, key_en_d, lk_en_q, lk_en_d, act_en_q, act_en_d;
    logic [KEY_OFF-1:0]   key_dat_q, key_dat_d;
    logic [ADDR_W-1:0]    key_addr_q, key_addr_d, lk_addr_q, lk_addr_d, act_addr_q, act_addr_d;
    logic [KEY_LEN-1:0]   lk_dat_q, lk_dat_d, lk_mask_q, lk_mask_d;
    logic [DAT_W-1:0]     act_dat_q, act_dat_d;
    logic                 inc, dec;

    // In-flight tracking: simultaneous ingress and egress cancel, so they never trip the bounds.
    always_comb begin
        inc    = bus.phv_in_valid & stg_ready_q;
        dec    = bus.phv_out_valid;
        cnt_d  = cnt_q;
        perr_d = perr_q;
        if (bus.phv_in_valid && !stg_ready_q) perr_d = 1'b1;
        if (inc && !dec) begin
            if (cnt_q == CNT_W'(PIPE_DEPTH)) perr_d = 1'b1;
            else                             cnt_d  = cnt_q + 1'b1;
        end else if (dec && !inc) begin
            if (cnt_q == '0) perr_d = 1'b1;
            else             cnt_d  = cnt_q - 1'b1;
        end
    end

    always_comb begin
        state_d     = state_q;
        stg_ready_d = stg_ready_q;
        cfg_ready_d = 1'b0;
        cfg_err_d   = 1'b0;
        tgt_d       = tgt_q;
        addr_d      = addr_q;
        data_d      = data_q;
        mask_d      = mask_q;
        settle_d    = settle_q;
        key_en_d    = 1'b0;
        lk_en_d     = 1'b0;
        act_en_d    = 1'b0;
        key_dat_d   = key_dat_q;
        key_addr_d  = key_addr_q;
        lk_dat_d    = lk_dat_q;
        lk_mask_d   = lk_mask_q;
        lk_addr_d   = lk_addr_q;
        act_dat_d   = act_dat_q;
        act_addr_d  = act_addr_q;
        case (state_q)
            IDLE: begin
                // The request is still held while cfg_ready is high; skip it to avoid a double consume.
                if (bus.cfg_valid && !cfg_ready_q) begin
                    if (bus.cfg_stage != 4'(STAGE)) begin
                        cfg_ready_d = 1'b1;
                    end else if (bus.cfg_target == 2'd3) begin
                        cfg_ready_d = 1'b1;
                        cfg_err_d   = 1'b1;
                    end else begin
                        tgt_d       = bus.cfg_target;
                        addr_d      = bus.cfg_addr;
                        data_d      = bus.cfg_data;
                        mask_d      = bus.cfg_mask;
                        stg_ready_d = 1'b0;
                        state_d     = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (cnt_q == '0) begin
                    state_d = WRITE;
                    case (tgt_q)
                        2'd0: begin
                            key_en_d   = 1'b1;
                            key_dat_d  = data_q[KEY_OFF-1:0];
                            key_addr_d = addr_q;
                        end
                        2'd1: begin
                            lk_en_d   = 1'b1;
                            lk_dat_d  = data_q[KEY_LEN-1:0];
                            lk_mask_d = mask_q;
                            lk_addr_d = addr_q;
                        end
                        default: begin
                            act_en_d   = 1'b1;
                            act_dat_d  = data_q;
                            act_addr_d = addr_q;
                        end
                    endcase
                end
            end
            WRITE: begin
                settle_d = '0;
                state_d  = SETTLE;
            end
            SETTLE: begin
                if (settle_q == 4'(SETTLE_CYC - 1)) begin
                    cfg_ready_d = 1'b1;
                    state_d     = DONE;
                end else begin
                    settle_d = settle_q + 1'b1;
                end
            end
            DONE: begin
                stg_ready_d = 1'b1;
                state_d     = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge axis_clk) begin
        if (axis_rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            perr_q      <= 1'b0;
            stg_ready_q <= 1'b1;
            cfg_ready_q <= 1'b0;
            cfg_err_q   <= 1'b0;
            tgt_q       <= '0;
            addr_q      <= '0;
            data_q      <= '0;
            mask_q      <= '0;
            settle_q    <= '0;
            key_en_q    <= 1'b0;
            lk_en_q     <= 1'b0;
            act_en_q    <= 1'b0;
            key_dat_q   <= '0;
            key_addr_q  <= '0;
            lk_dat_q    <= '0;
            lk_mask_q   <= '0;
            lk_addr_q   <= '0;
            act_dat_q   <= '0;
            act_addr_q  <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            perr_q      <= perr_d;
            stg_ready_q <= stg_ready_d;
            cfg_ready_q <= cfg_ready_d;
            cfg_err_q   <= cfg_err_d;
            tgt_q       <= tgt_d;
            addr_q      <= addr_d;
            data_q      <= data_d;
            mask_q      <= mask_d;
            settle_q    <= settle_d;
            key_en_q    <= key_en_d;
            lk_en_q     <= lk_en_d;
            act_en_q    <= act_en_d;
            key_dat_q   <= key_dat_d;
            key_addr_q  <= key_addr_d;
            lk_dat_q    <= lk_dat_d;
            lk_mask_q   <= lk_mask_d;
            lk_addr_q   <= lk_addr_d;
            act_dat_q   <= act_dat_d;
            act_addr_q  <= act_addr_d;
        end
    end

    assign bus.stg_ready              = stg_ready_q;
    assign bus.cfg_ready              = cfg_ready_q;
    assign bus.cfg_err                = cfg_err_q;
    assign bus.protocol_err           = perr_q;
    assign bus.key_off_entry_in       = key_dat_q;
    assign bus.key_off_entry_in_valid = key_en_q;
    assign bus.key_off_entry_addr     = key_addr_q;
    assign bus.lookup_din             = lk_dat_q;
    assign bus.lookup_din_mask        = lk_mask_q;
    assign bus.lookup_din_addr        = lk_addr_q;
    assign bus.lookup_din_en          = lk_en_q;
    assign bus.action_data_in         = act_dat_q;
    assign bus.action_addr            = act_addr_q;
    assign bus.action_en              = act_en_q;
endmodule

// File: tb/tb_stage_cfg_sched.sv
// Directed cycle table for stage_cfg_sched plus hand-written data-hold and latency sequences.
module tb_stage_cfg_sched;
    localparam int KEY_OFF = 18;
    localparam int KEY_LEN = 197;
    localparam int ACT_LEN = 25;
    localparam int ADDR_W  = 4;
    localparam int DAT_W   = ACT_LEN * 25;

    // expected flag order: {stg_ready, cfg_ready, cfg_err, key_en, lookup_en, action_en, protocol_err}
    localparam logic [6:0] S  = 7'b1000000;
    localparam logic [6:0] Z  = 7'b0000000;
    localparam logic [6:0] CR = 7'b0100000;
    localparam logic [6:0] PE = 7'b1000001;
    // control order: {rst, phv_in, phv_out, cfg_valid}
    localparam logic [3:0] I   = 4'b0000;
    localparam logic [3:0] Q   = 4'b0001;
    localparam logic [3:0] QI  = 4'b0101;
    localparam logic [3:0] QO  = 4'b0011;
    localparam logic [3:0] PI  = 4'b0100;
    localparam logic [3:0] PO  = 4'b0010;
    localparam logic [3:0] PIO = 4'b0110;
    localparam logic [3:0] RST = 4'b1000;
    localparam logic [3:0] RQ  = 4'b1001;

    typedef struct {
        logic [3:0] ctl;
        logic [3:0] stg;
        logic [1:0] tgt;
        logic [3:0] addr;
        logic [6:0] exp;
        logic [3:0] eaddr;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    int   n_cmp = 0;
    int   n_bad = 0;
    vec_t tbl[$];
    logic [DAT_W-1:0]   d0, d1;
    logic [KEY_LEN-1:0] m_ones, m1;

    always #5 clk = ~clk;

    stage_cfg_sched_if #(.KEY_OFF(KEY_OFF), .KEY_LEN(KEY_LEN), .ACT_LEN(ACT_LEN), .ADDR_W(ADDR_W)) bus ();

    stage_cfg_sched #(
        .STAGE(0), .PIPE_DEPTH(8), .KEY_OFF(KEY_OFF), .KEY_LEN(KEY_LEN),
        .ACT_LEN(ACT_LEN), .ADDR_W(ADDR_W), .SETTLE_CYC(2)
    ) dut (
        .axis_clk (clk),
        .axis_rst (rst),
        .bus      (bus)
    );

    task automatic chk(input string nm, input logic [639:0] got, input logic [639:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
        end
    endtask

    task automatic add(input logic [3:0] ctl, input logic [3:0] stg, input logic [1:0] tgt,
                       input logic [3:0] addr, input logic [6:0] exp, input logic [3:0] eaddr);
        vec_t v;
        v.ctl = ctl; v.stg = stg; v.tgt = tgt; v.addr = addr; v.exp = exp; v.eaddr = eaddr;
        tbl.push_back(v);
    endtask

    task automatic do_req(input logic [1:0] tgt, input logic [3:0] addr,
                          output int lat, output int nk, output int nl, output int na);
        @(negedge clk);
        bus.cfg_valid = 1'b1; bus.cfg_stage = 4'd0; bus.cfg_target = tgt; bus.cfg_addr = addr;
        lat = -1; nk = 0; nl = 0; na = 0;
        for (int c = 1; c <= 30; c++) begin
            @(negedge clk);
            nk += int'(bus.key_off_entry_in_valid);
            nl += int'(bus.lookup_din_en);
            na += int'(bus.action_en);
            if (bus.cfg_ready) begin
                lat = c;
                break;
            end
        end
        bus.cfg_valid = 1'b0;
    endtask

    function automatic logic [6:0] flags();
        return {bus.stg_ready, bus.cfg_ready, bus.cfg_err, bus.key_off_entry_in_valid,
                bus.lookup_din_en, bus.action_en, bus.protocol_err};
    endfunction

    initial begin
        int lat, nk, nl, na;
        d0     = {25{25'h1ABCDE5}};
        d1     = {25{25'h0F0F0F3}};
        m_ones = '1;
        m1     = {1'b1, {98{2'b01}}};

        // lookup, empty stage, addr 3: write T+2, cfg_ready T+5, stg_ready back T+6
        add(I,0,0,0,S,0);
        add(Q,0,1,3,S,0);
        add(Q,0,1,3,Z,0);
        add(Q,0,1,3,7'b0000100,3);
        add(Q,0,1,3,Z,0);
        add(Q,0,1,3,Z,0);
        add(Q,0,1,3,CR,0);
        add(I,0,0,0,S,0);
        // other stage, then illegal target; valid still high on the cfg_ready cycle
        add(Q,2,1,7,S,0);
        add(Q,2,1,7,7'b1100000,0);
        add(I,0,0,0,S,0);
        add(Q,0,3,1,S,0);
        add(Q,0,3,1,7'b1110000,0);
        add(I,0,0,0,S,0);
        // action with 3 in flight (third counted in request cycle); egress T+4,T+6,T+9 -> write T+11
        add(PI,0,0,0,S,0);
        add(PI,0,0,0,S,0);
        add(QI,0,2,6,S,0);
        add(Q,0,2,6,Z,0);
        add(Q,0,2,6,Z,0);
        add(Q,0,2,6,Z,0);
        add(QO,0,2,6,Z,0);
        add(Q,0,2,6,Z,0);
        add(QO,0,2,6,Z,0);
        add(Q,0,2,6,Z,0);
        add(Q,0,2,6,Z,0);
        add(QO,0,2,6,Z,0);
        add(Q,0,2,6,Z,0);
        add(Q,0,2,6,7'b0000010,6);
        add(Q,0,2,6,Z,0);
        add(Q,0,2,6,Z,0);
        add(Q,0,2,6,CR,0);
        add(I,0,0,0,S,0);
        // count to 2, five cancelling cycles, drain to 0, one extra egress underflows
        add(PI,0,0,0,S,0);
        add(PI,0,0,0,S,0);
        for (int k = 0; k < 5; k++) add(PIO,0,0,0,S,0);
        add(PO,0,0,0,S,0);
        add(PO,0,0,0,S,0);
        add(PO,0,0,0,S,0);
        add(I,0,0,0,PE,0);
        add(I,0,0,0,PE,0);
        add(RST,0,0,0,PE,0);
        add(I,0,0,0,S,0);
        // PHV pushed during DRAIN: error, not counted, write still at T+2
        add(Q,0,2,9,S,0);
        add(QI,0,2,9,Z,0);
        add(Q,0,2,9,7'b0000011,9);
        add(Q,0,2,9,7'b0000001,0);
        add(Q,0,2,9,7'b0000001,0);
        add(Q,0,2,9,7'b0100001,0);
        add(I,0,0,0,PE,0);
        add(RST,0,0,0,PE,0);
        add(I,0,0,0,S,0);
        // reset during SETTLE: no cfg_ready, then a key_off write at addr 5 completes normally
        add(Q,0,1,12,S,0);
        add(Q,0,1,12,Z,0);
        add(Q,0,1,12,7'b0000100,12);
        add(RQ,0,1,12,Z,0);
        add(I,0,0,0,S,0);
        add(I,0,0,0,S,0);
        add(Q,0,0,5,S,0);
        add(Q,0,0,5,Z,0);
        add(Q,0,0,5,7'b0001000,5);
        add(Q,0,0,5,Z,0);
        add(Q,0,0,5,Z,0);
        add(Q,0,0,5,CR,0);
        add(I,0,0,0,S,0);

        rst = 1'b1;
        bus.phv_in_valid = 1'b0; bus.phv_out_valid = 1'b0; bus.cfg_valid = 1'b0;
        bus.cfg_stage = 4'd0; bus.cfg_target = 2'd0; bus.cfg_addr = '0;
        bus.cfg_data = d0; bus.cfg_mask = m_ones;
        @(negedge clk);
        @(negedge clk);
        chk("reset_flags", 640'(flags()), 640'(S));
        chk("reset_key_dat", 640'(bus.key_off_entry_in), 640'(0));
        chk("reset_lk_dat", 640'(bus.lookup_din), 640'(0));
        chk("reset_lk_mask", 640'(bus.lookup_din_mask), 640'(0));
        chk("reset_act_dat", 640'(bus.action_data_in), 640'(0));
        chk("reset_addrs", 640'({bus.key_off_entry_addr, bus.lookup_din_addr, bus.action_addr}), 640'(0));

        for (int i = 0; i < tbl.size(); i++) begin
            @(negedge clk);
            rst               = tbl[i].ctl[3];
            bus.phv_in_valid  = tbl[i].ctl[2];
            bus.phv_out_valid = tbl[i].ctl[1];
            bus.cfg_valid     = tbl[i].ctl[0];
            bus.cfg_stage     = tbl[i].stg;
            bus.cfg_target    = tbl[i].tgt;
            bus.cfg_addr      = tbl[i].addr;
            chk($sformatf("row%0d_flags", i), 640'(flags()), 640'(tbl[i].exp));
            if (tbl[i].exp[3]) chk($sformatf("row%0d_key_addr", i), 640'(bus.key_off_entry_addr), 640'(tbl[i].eaddr));
            if (tbl[i].exp[2]) chk($sformatf("row%0d_lk_addr", i), 640'(bus.lookup_din_addr), 640'(tbl[i].eaddr));
            if (tbl[i].exp[1]) chk($sformatf("row%0d_act_addr", i), 640'(bus.action_addr), 640'(tbl[i].eaddr));
        end

        @(negedge clk);
        bus.cfg_valid = 1'b0; bus.phv_in_valid = 1'b0; bus.phv_out_valid = 1'b0; rst = 1'b0;
        chk("hold_key_dat", 640'(bus.key_off_entry_in), 640'(d0[KEY_OFF-1:0]));
        chk("hold_key_addr", 640'(bus.key_off_entry_addr), 640'(5));
        chk("rst_cleared_lk_addr", 640'(bus.lookup_din_addr), 640'(0));
        chk("rst_cleared_act_dat", 640'(bus.action_data_in), 640'(0));

        // lookup with a patterned mask and new data; key_off outputs must keep the old value
        bus.cfg_data = d1;
        bus.cfg_mask = m1;
        do_req(2'd1, 4'd10, lat, nk, nl, na);
        chk("seq_latency", 640'(lat), 640'(5));
        chk("seq_lk_strobes", 640'(nl), 640'(1));
        chk("seq_other_strobes", 640'(nk + na), 640'(0));
        chk("seq_lk_dat", 640'(bus.lookup_din), 640'(d1[KEY_LEN-1:0]));
        chk("seq_lk_mask", 640'(bus.lookup_din_mask), 640'(m1));
        chk("seq_lk_addr", 640'(bus.lookup_din_addr), 640'(10));
        chk("seq_key_hold", 640'(bus.key_off_entry_in), 640'(d0[KEY_OFF-1:0]));
        @(negedge clk);
        chk("seq_release", 640'(flags()), 640'(S));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
